// File: rtl/ex_muldiv_pkg.sv
// Shared widths, op codes, stall levels and divider state encodings for ex_muldiv.
package ex_muldiv_pkg;

  localparam int RegBus   = 32;
  localparam int AluOpBus = 8;
  localparam int StallBus = 6;

  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [AluOpBus-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [AluOpBus-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input logic [AluOpBus-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX-side bundle of the multiply/divide unit: op, operands, stall/flush in; stall request and HI/LO out.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic [AluOpBus-1:0] aluop_i;
  logic [RegBus-1:0]   rdata1_i;
  logic [RegBus-1:0]   rdata2_i;
  logic [StallBus-1:0] stall_i;
  logic                annul_i;
  logic                stallreq_o;
  logic [RegBus-1:0]   result_o;
  logic [RegBus-1:0]   hi_o;
  logic [RegBus-1:0]   lo_o;

  modport master (
    output aluop_i, rdata1_i, rdata2_i, stall_i, annul_i,
    input  stallreq_o, result_o, hi_o, lo_o
  );

  modport slave (
    input  aluop_i, rdata1_i, rdata2_i, stall_i, annul_i,
    output stallreq_o, result_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// Unsigned 32-step restoring divider; done is high in the cycle whose edge performs the last step.
module div_core
  import ex_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [RegBus-1:0] dividend,
  input  logic [RegBus-1:0] divisor,
  output logic              done,
  output logic [RegBus-1:0] quotient,
  output logic [RegBus-1:0] remainder
);
  logic              busy;
  logic [4:0]        count;
  logic [RegBus-1:0] quo, rem, den;
  logic [RegBus:0]   trial;

  // rem < den always holds, so the shifted partial remainder fits in 33 bits
  assign trial = {rem, quo[RegBus-1]} - {1'b0, den};

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy  <= 1'b0;
      count <= 5'd0;
      quo   <= ZeroWord;
      rem   <= ZeroWord;
      den   <= ZeroWord;
    end else if (start) begin
      busy  <= 1'b1;
      count <= 5'd0;
      quo   <= dividend;
      rem   <= ZeroWord;
      den   <= divisor;
    end else if (busy) begin
      rem   <= trial[RegBus] ? {rem[RegBus-2:0], quo[RegBus-1]} : trial[RegBus-1:0];
      quo   <= {quo[RegBus-2:0], ~trial[RegBus]};
      count <= count + 5'd1;
      if (count == 5'd31) busy <= 1'b0;
    end
  end

  assign done      = busy && (count == 5'd31);
  assign quotient  = quo;
  assign remainder = rem;
endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit with HI/LO registers.
// The iterative divider is compiled in only when MULDIV_DIV_EN is defined.
//
// state    | meaning
// DIV_IDLE | no divide in flight; launches on DIV/DIVU
// DIV_RUN  | one restoring step per cycle, stall requested
// DIV_DONE | signed-corrected results ready, written when MEM advances
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);
  logic [RegBus-1:0] a, b, hi, lo;
  logic [63:0]       prod_s, prod_u;
  logic              commit, div_wr;
  logic [RegBus-1:0] div_q, div_r;

  assign a      = bus.rdata1_i;
  assign b      = bus.rdata2_i;
  assign commit = (bus.stall_i[3] == NoStop) && !bus.annul_i;
  // low 64 bits of the sign-extended product equal the signed 32x32 product
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

`ifdef MULDIV_DIV_EN
  div_state_t        state, state_nxt;
  logic              is_div, div_signed, b_zero, launch;
  logic              sign_a, sign_b, dz;
  logic              core_start, core_done, stallreq;
  logic [RegBus-1:0] a_hold, abs_a, abs_b, core_q, core_r;

  assign is_div     = is_div_op(bus.aluop_i);
  assign div_signed = (bus.aluop_i == EXE_DIV_OP);
  assign b_zero     = (b == ZeroWord);
  assign launch     = (state == DIV_IDLE) && is_div && !bus.annul_i;
  assign abs_a      = (div_signed && a[31]) ? -a : a;
  assign abs_b      = (div_signed && b[31]) ? -b : b;

  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (launch) state_nxt = b_zero ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        if (bus.annul_i)    state_nxt = DIV_IDLE;
        else if (core_done) state_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        if (bus.annul_i || bus.stall_i[3] == NoStop) state_nxt = DIV_IDLE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_comb begin
    stallreq   = 1'b0;
    core_start = 1'b0;
    div_wr     = 1'b0;
    case (state)
      DIV_IDLE: begin
        stallreq   = launch;
        core_start = launch && !b_zero;
      end
      DIV_RUN:  stallreq = !bus.annul_i;
      DIV_DONE: div_wr   = commit;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz     <= 1'b0;
      a_hold <= ZeroWord;
    end else if (launch) begin
      sign_a <= div_signed && a[31];
      sign_b <= div_signed && b[31];
      dz     <= b_zero;
      a_hold <= a;
    end
  end

  div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .abort     (bus.annul_i),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // 0x80000000 / -1 falls out naturally: |q| = 0x80000000 negates to itself
  assign div_q          = dz ? '1 : ((sign_a ^ sign_b) ? -core_q : core_q);
  assign div_r          = dz ? a_hold : (sign_a ? -core_r : core_r);
  assign bus.stallreq_o = stallreq;
`else
  assign div_wr         = 1'b0;
  assign div_q          = ZeroWord;
  assign div_r          = ZeroWord;
  assign bus.stallreq_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (div_wr) begin
      hi <= div_r;
      lo <= div_q;
    end else if (commit) begin
      case (bus.aluop_i)
        EXE_MULT_OP:  {hi, lo} <= prod_s;
        EXE_MULTU_OP: {hi, lo} <= prod_u;
        EXE_MTHI_OP:  hi <= a;
        EXE_MTLO_OP:  lo <= a;
        default: ;
      endcase
    end
  end

  assign bus.result_o = (bus.aluop_i == EXE_MFHI_OP) ? hi :
                        (bus.aluop_i == EXE_MFLO_OP) ? lo : ZeroWord;
  assign bus.hi_o     = hi;
  assign bus.lo_o     = lo;
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Execute-stage multiply/divide unit with architectural HI/LO registers. Consumes the operation code and operands issued from the ID/EX pipeline register. Multiplies complete in one cycle. Divides run on an iterative 32-step restoring divider, and the unit holds `stallreq_o` high until the quotient and remainder are ready. Results for MFHI/MFLO are returned to the EX result mux.

## Interface
Parameters:
- none; widths come from shared defines (`RegBus` = 32, `AluOpBus` = 8, `StallBus` = 6).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- aluop_i  in  8  operation from ID/EX: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO; anything else is a no-op here
- rdata1_i  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
- rdata2_i  in  32  operand B (divisor / multiplier)
- stall_i  in  6  pipeline stall vector; bit 3 = MEM stage stopped
- annul_i  in  1  flush; aborts any divide and suppresses the HI/LO write this cycle
- stallreq_o  out  1  EX stall request to the pipeline controller
- result_o  out  32  HI for MFHI, LO for MFLO, else 0
- hi_o  out  32  current HI register
- lo_o  out  32  current LO register

## Operation
- Commit condition for any HI/LO write: stall_i[3] = NoStop and annul_i = 0.
- MULT/MULTU: 64-bit product of the operands, signed or unsigned. On commit, HI ← product[63:32] and LO ← product[31:0].
- MTHI/MTLO: on commit, HI or LO ← rdata1_i.
- MFHI/MFLO: result_o is the register value, combinational. It reflects every write committed on earlier edges.
- DIV/DIVU state machine, states IDLE, RUN, DONE:
  - IDLE with a divide op and annul_i = 0, divisor ≠ 0: latch |A| and |B| (raw values for DIVU) plus the sign flags. Count ← 0. Go to RUN. stallreq_o = 1 in this cycle.
  - IDLE with divisor = 0: go to DONE with quotient = 0xFFFFFFFF and remainder = A. stallreq_o = 1.
  - RUN: one restoring shift-subtract step per cycle. After step 31, go to DONE. stallreq_o = 1.
  - DONE: stallreq_o = 0.
    - If stall_i[3] = Stop, stay in DONE and hold the results.
    - Otherwise, on the edge: HI ← remainder and LO ← quotient, then go to IDLE.
- Signed fix-up applies in DONE before output:
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000 and remainder 0.
- annul_i = 1 in any state: go to IDLE next edge, no HI/LO write, stallreq_o = 0 in that cycle.
- stall_i[3] does not pause RUN; iteration continues regardless.

## Timing
- Reset: HI = 0, LO = 0, state IDLE, count 0. stallreq_o = 0, result_o = 0, hi_o = lo_o = 0.
- rst mid-divide: abort immediately, no write.
- MULT/MTxx: write on the first edge after issue. A dependent MFxx in the next cycle sees the new value.
- Divide with nonzero divisor: stallreq_o high for 33 cycles (1 IDLE cycle + 32 RUN cycles). The next cycle is DONE. HI/LO are written at the end of DONE, 34 cycles after issue.
- Divide by zero: stallreq_o high for 1 cycle, DONE in cycle 2, write at end of cycle 2.
- The divide op stays on aluop_i while stallreq_o is high. In DONE the held op is ignored, so there is no re-launch.

## Configuration
- `MULDIV_DIV_EN` defined: divider and FSM are compiled in, with behaviour as above.
- `MULDIV_DIV_EN` undefined: DIV/DIVU are no-ops. There is no HI/LO write, stallreq_o is tied to 0, and the divider is not instantiated.
- MULT and MTxx/MFxx are unaffected either way.

## Structure
- Shared defines file holds:
  - op codes `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP`, `EXE_MFHI_OP`, `EXE_MFLO_OP`
  - `Stop`/`NoStop`, `RegBus`, `AluOpBus`, `StallBus`, `ZeroWord`
  - divider state encodings
- One sub-module, `div_core`: unsigned 32-step restoring divider. It takes start, dividend, divisor, and abort, and returns done, quotient, and remainder. Sign handling and HI/LO stay in `ex_muldiv`.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2 → stallreq_o high for 33 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIVU 5 / 0 → 1 stall cycle, LO = 0xFFFFFFFF, HI = 5. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIV in progress, annul_i pulsed at RUN step 10 → stallreq_o drops next cycle, HI/LO unchanged, a following MULT works normally.
- DIV reaches DONE with stall_i[3] = Stop for 3 cycles → results held, no write until stall_i[3] releases, then a single write.
- MTHI 0x12345678 followed immediately by MFHI → result_o = 0x12345678. With `MULDIV_DIV_EN` undefined, DIV → no stall, HI/LO unchanged.
